// File: rtl/count_fifo_reader.sv
// Pops one 25-bit count word from a FIFO and serialises it as a 6-byte frame:
// sync, mode, count[23:16], count[15:8], count[7:0], XOR checksum.
module count_fifo_reader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 24
) (
    input  logic             clk_12mhz,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [CNT_W:0]   fifo_dout,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic [1:0]       state_dbg
);

    // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; tx_data
    // holds until then, and tx_ready is don't-care while tx_valid is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [CNT_W:0] shadow_q, shadow_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    logic [7:0]     mode_byte;
    logic [7:0]     checksum;
    logic [7:0]     frame_byte;

    assign mode_byte = {7'b0, shadow_q[CNT_W]};
    assign checksum  = mode_byte ^ shadow_q[23:16] ^ shadow_q[15:8] ^ shadow_q[7:0];

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = mode_byte;
            3'd2:    frame_byte = shadow_q[23:16];
            3'd3:    frame_byte = shadow_q[15:8];
            3'd4:    frame_byte = shadow_q[7:0];
            3'd5:    frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        frame_cnt_d = frame_cnt_q;
        fifo_rd_en  = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state_q)
            IDLE: begin
                // Reset gating keeps a pop from being lost while the FSM is cleared.
                if (!fifo_empty && !reset) begin
                    fifo_rd_en = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                shadow_d = fifo_dout;
                idx_d    = 3'd0;
                state_d  = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_byte;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = 3'd0;
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            shadow_q    <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign state_dbg = state_q;

endmodule
